// File: rtl/ddr3_mcb_seq_pkg.sv
// Shared types and default timing for the DDR3 command sequencer.
package ddr3_mcb_seq_pkg;

    localparam int CNT_W = 16;

    localparam int DEF_T_RST  = 8;
    localparam int DEF_T_CKE  = 8;
    localparam int DEF_T_MRD  = 4;
    localparam int DEF_T_MOD  = 12;
    localparam int DEF_T_ZQ   = 64;
    localparam int DEF_T_RCD  = 6;
    localparam int DEF_T_RTP  = 4;
    localparam int DEF_T_RP   = 6;
    localparam int DEF_T_RFC  = 44;
    localparam int DEF_T_REFI = 3120;

    typedef enum logic [2:0] {
        I_RST, I_CKE, I_LMR0, I_LMR1, I_LMR2, I_LMR3, I_ZQ, I_DONE
    } init_state_e;

    typedef enum logic [2:0] {
        R_IDLE, R_BB, R_ACT, R_COL, R_PRE, R_PREA, R_REF
    } run_state_e;

    typedef struct packed {
        logic i_rst, i_cke, i_lmr0, i_lmr1, i_lmr2, i_lmr3, i_zq;
        logic c_prea, c_ref, c_prec, c_act, c_rd, c_wr;
    } strobe_t;

    // Load value that makes the next command land exactly t cycles after this one.
    function automatic logic [CNT_W-1:0] gap(input int t);
        return CNT_W'(t - 1);
    endfunction

endpackage

// File: rtl/ddr3_mcb_seq_timer.sv
// Loadable saturating down-counter; done is high while the count is zero.
module ddr3_mcb_seq_timer
    import ddr3_mcb_seq_pkg::*;
(
    input  logic             ddr3_mcb_clk,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // NOTE: no reset term here; the owner asserts load during reset, which initialises the count.
    always_ff @(posedge ddr3_mcb_clk) begin
        if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/ddr3_mcb_seq.sv
// DDR3 init/refresh/closed-page command sequencer.
// Refresh path is built only when DDR3_MCB_SEQ_REF_EN is defined.
module ddr3_mcb_seq
    import ddr3_mcb_seq_pkg::*;
#(
    parameter int B_W    = 3,
    parameter int R_W    = 14,
    parameter int C_W    = 10,
    parameter int T_RST  = DEF_T_RST,
    parameter int T_CKE  = DEF_T_CKE,
    parameter int T_MRD  = DEF_T_MRD,
    parameter int T_MOD  = DEF_T_MOD,
    parameter int T_ZQ   = DEF_T_ZQ,
    parameter int T_RCD  = DEF_T_RCD,
    parameter int T_RTP  = DEF_T_RTP,
    parameter int T_RP   = DEF_T_RP,
    parameter int T_RFC  = DEF_T_RFC,
    parameter int T_REFI = DEF_T_REFI
) (
    input  logic           ddr3_mcb_clk,
    input  logic           ddr3_mcb_rst,
    input  logic           req_valid,
    input  logic           req_rd,
    input  logic [B_W-1:0] req_ba,
    input  logic [R_W-1:0] req_ra,
    input  logic [C_W-1:0] req_ca,
    output logic           req_ready,
    output logic           seq_bb,
    output logic [B_W-1:0] seq_ba,
    output logic [R_W-1:0] seq_ra,
    output logic [C_W-1:0] seq_ca,
    output logic           i_rst,
    output logic           i_cke,
    output logic           i_lmr0,
    output logic           i_lmr1,
    output logic           i_lmr2,
    output logic           i_lmr3,
    output logic           i_zq,
    output logic           c_prea,
    output logic           c_ref,
    output logic           c_prec,
    output logic           c_act,
    output logic           c_rd,
    output logic           c_wr,
    output logic           init_done
);

    init_state_e      init_q, init_d;
    run_state_e       run_q, run_d;
    strobe_t          strb_q, strb_d;
    logic             seq_bb_d;
    logic             rd_q;
    logic             accept;
    logic             ref_pend;
    logic             ref_clr;
    logic             gap_load, gap_load_eff;
    logic [CNT_W-1:0] gap_val, gap_val_eff;
    logic             gap_done;

    assign req_ready = (init_q == I_DONE) && (run_q == R_IDLE) && !ref_pend;
    assign accept    = req_valid && req_ready;

    // Reset preloads the full T_RST so the first post-reset cycle already counts.
    assign gap_load_eff = ddr3_mcb_rst || gap_load;
    assign gap_val_eff  = ddr3_mcb_rst ? CNT_W'(T_RST) : gap_val;

    ddr3_mcb_seq_timer u_gap_timer (
        .ddr3_mcb_clk (ddr3_mcb_clk),
        .load         (gap_load_eff),
        .value        (gap_val_eff),
        .done         (gap_done)
    );

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        init_d   = init_q;
        run_d    = run_q;
        strb_d   = '0;
        seq_bb_d = 1'b0;
        gap_load = 1'b0;
        gap_val  = '0;
        ref_clr  = 1'b0;

        case (init_q)
            I_RST: if (gap_done) begin
                init_d = I_CKE; gap_load = 1'b1; gap_val = gap(T_CKE);
            end
            I_CKE: if (gap_done) begin
                init_d = I_LMR0; strb_d.i_lmr0 = 1'b1; gap_load = 1'b1; gap_val = gap(T_MRD);
            end
            I_LMR0: if (gap_done) begin
                init_d = I_LMR1; strb_d.i_lmr1 = 1'b1; gap_load = 1'b1; gap_val = gap(T_MRD);
            end
            I_LMR1: if (gap_done) begin
                init_d = I_LMR2; strb_d.i_lmr2 = 1'b1; gap_load = 1'b1; gap_val = gap(T_MRD);
            end
            I_LMR2: if (gap_done) begin
                init_d = I_LMR3; strb_d.i_lmr3 = 1'b1; gap_load = 1'b1; gap_val = gap(T_MOD);
            end
            I_LMR3: if (gap_done) begin
                init_d = I_ZQ; strb_d.i_zq = 1'b1; gap_load = 1'b1; gap_val = gap(T_ZQ);
            end
            I_ZQ: if (gap_done) begin
                init_d = I_DONE;
            end
            I_DONE: begin
                case (run_q)
                    R_IDLE: begin
                        if (ref_pend) begin
                            run_d = R_PREA; strb_d.c_prea = 1'b1;
                            gap_load = 1'b1; gap_val = gap(T_RP);
                        end else if (accept) begin
                            run_d = R_BB; seq_bb_d = 1'b1;
                        end
                    end
                    R_BB: begin
                        run_d = R_ACT; strb_d.c_act = 1'b1;
                        gap_load = 1'b1; gap_val = gap(T_RCD);
                    end
                    R_ACT: if (gap_done) begin
                        run_d = R_COL; strb_d.c_rd = rd_q; strb_d.c_wr = !rd_q;
                        gap_load = 1'b1; gap_val = gap(T_RTP);
                    end
                    R_COL: if (gap_done) begin
                        run_d = R_PRE; strb_d.c_prec = 1'b1;
                        gap_load = 1'b1; gap_val = gap(T_RP);
                    end
                    R_PRE: if (gap_done) begin
                        run_d = R_IDLE;
                    end
                    R_PREA: if (gap_done) begin
                        run_d = R_REF; strb_d.c_ref = 1'b1; ref_clr = 1'b1;
                        gap_load = 1'b1; gap_val = gap(T_RFC);
                    end
                    R_REF: if (gap_done) begin
                        run_d = R_IDLE;
                    end
                    default: run_d = R_IDLE;
                endcase
            end
            default: init_d = I_RST;
        endcase

        // Level holds follow the state being entered.
        strb_d.i_rst = (init_d == I_RST);
        strb_d.i_cke = (init_d == I_CKE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge ddr3_mcb_clk) begin
        if (ddr3_mcb_rst) begin
            init_q    <= I_RST;
            run_q     <= R_IDLE;
            strb_q    <= '0;
            seq_bb    <= 1'b0;
            rd_q      <= 1'b0;
            seq_ba    <= '0;
            seq_ra    <= '0;
            seq_ca    <= '0;
            init_done <= 1'b0;
        end else begin
            init_q    <= init_d;
            run_q     <= run_d;
            strb_q    <= strb_d;
            seq_bb    <= seq_bb_d;
            init_done <= init_done || (init_d == I_DONE);
            if (accept) begin
                seq_ba <= req_ba;
                seq_ra <= req_ra;
                seq_ca <= req_ca;
                rd_q   <= req_rd;
            end
        end
    end

`ifdef DDR3_MCB_SEQ_REF_EN
    logic ref_load, ref_done, ref_expire;

    assign ref_expire = init_done && ref_done;
    assign ref_load   = ddr3_mcb_rst || ref_expire || ((init_d == I_DONE) && !init_done);

    ddr3_mcb_seq_timer u_ref_timer (
        .ddr3_mcb_clk (ddr3_mcb_clk),
        .load         (ref_load),
        .value        (gap(T_REFI)),
        .done         (ref_done)
    );

    // A fresh expiry wins over the clear; a second expiry while pending is absorbed.
    always_ff @(posedge ddr3_mcb_clk) begin
        if (ddr3_mcb_rst) begin
            ref_pend <= 1'b0;
        end else begin
            ref_pend <= (ref_pend && !ref_clr) || ref_expire;
        end
    end
`else
    logic unused_ref;

    assign ref_pend   = 1'b0;
    assign unused_ref = ref_clr ^ (T_REFI == 0);
`endif

    assign i_rst  = strb_q.i_rst;
    assign i_cke  = strb_q.i_cke;
    assign i_lmr0 = strb_q.i_lmr0;
    assign i_lmr1 = strb_q.i_lmr1;
    assign i_lmr2 = strb_q.i_lmr2;
    assign i_lmr3 = strb_q.i_lmr3;
    assign i_zq   = strb_q.i_zq;
    assign c_prea = strb_q.c_prea;
    assign c_ref  = strb_q.c_ref;
    assign c_prec = strb_q.c_prec;
    assign c_act  = strb_q.c_act;
    assign c_rd   = strb_q.c_rd;
    assign c_wr   = strb_q.c_wr;

endmodule

// File: tb/tb_ddr3_mcb_seq.sv
// Directed, table-driven bench for ddr3_mcb_seq: init, read/write, reset abort, refresh.
module tb_ddr3_mcb_seq;

    localparam logic [12:0] S_NONE = 13'h0000, S_RST  = 13'h1000, S_CKE  = 13'h0800,
                            S_LMR0 = 13'h0400, S_LMR1 = 13'h0200, S_LMR2 = 13'h0100,
                            S_LMR3 = 13'h0080, S_ZQ   = 13'h0040, S_PREA = 13'h0020,
                            S_REF  = 13'h0010, S_PREC = 13'h0008, S_ACT  = 13'h0004,
                            S_RD   = 13'h0002, S_WR   = 13'h0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT a: default timing.  DUT b: T_REFI = 50.
    logic        rst_a, a_valid, a_rd, a_ready, a_bb, a_done;
    logic [2:0]  a_ba, a_sba;
    logic [13:0] a_ra, a_sra;
    logic [9:0]  a_ca, a_sca;
    logic        a_irst, a_icke, a_l0, a_l1, a_l2, a_l3, a_zq, a_prea, a_ref, a_prec, a_act, a_crd, a_cwr;
    logic [12:0] a_strb;

    logic        rst_b, b_valid, b_rd, b_ready, b_bb, b_done;
    logic [2:0]  b_ba, b_sba;
    logic [13:0] b_ra, b_sra;
    logic [9:0]  b_ca, b_sca;
    logic        b_irst, b_icke, b_l0, b_l1, b_l2, b_l3, b_zq, b_prea, b_ref, b_prec, b_act, b_crd, b_cwr;
    logic [12:0] b_strb;

    assign a_strb = {a_irst, a_icke, a_l0, a_l1, a_l2, a_l3, a_zq, a_prea, a_ref, a_prec, a_act, a_crd, a_cwr};
    assign b_strb = {b_irst, b_icke, b_l0, b_l1, b_l2, b_l3, b_zq, b_prea, b_ref, b_prec, b_act, b_crd, b_cwr};

    ddr3_mcb_seq dut (
        .ddr3_mcb_clk(clk), .ddr3_mcb_rst(rst_a),
        .req_valid(a_valid), .req_rd(a_rd), .req_ba(a_ba), .req_ra(a_ra), .req_ca(a_ca),
        .req_ready(a_ready), .seq_bb(a_bb), .seq_ba(a_sba), .seq_ra(a_sra), .seq_ca(a_sca),
        .i_rst(a_irst), .i_cke(a_icke), .i_lmr0(a_l0), .i_lmr1(a_l1), .i_lmr2(a_l2), .i_lmr3(a_l3),
        .i_zq(a_zq), .c_prea(a_prea), .c_ref(a_ref), .c_prec(a_prec), .c_act(a_act),
        .c_rd(a_crd), .c_wr(a_cwr), .init_done(a_done)
    );

    ddr3_mcb_seq #(.T_REFI(50)) dut_ref (
        .ddr3_mcb_clk(clk), .ddr3_mcb_rst(rst_b),
        .req_valid(b_valid), .req_rd(b_rd), .req_ba(b_ba), .req_ra(b_ra), .req_ca(b_ca),
        .req_ready(b_ready), .seq_bb(b_bb), .seq_ba(b_sba), .seq_ra(b_sra), .seq_ca(b_sca),
        .i_rst(b_irst), .i_cke(b_icke), .i_lmr0(b_l0), .i_lmr1(b_l1), .i_lmr2(b_l2), .i_lmr3(b_l3),
        .i_zq(b_zq), .c_prea(b_prea), .c_ref(b_ref), .c_prec(b_prec), .c_act(b_act),
        .c_rd(b_crd), .c_wr(b_cwr), .init_done(b_done)
    );

    int cyc_a = 0, cyc_b = 0;
    always @(posedge clk) cyc_a <= rst_a ? 0 : cyc_a + 1;
    always @(posedge clk) cyc_b <= rst_b ? 0 : cyc_b + 1;

    int n_chk = 0, n_err = 0;
    int overlap = 0, a_col_cnt = 0, b_ref_cnt = 0, b_acc = 0, b_last = 0, b_gap_bad = 0;

    always @(negedge clk) begin
        if ($countones(a_strb) > 1 || $countones(b_strb) > 1) overlap++;
        if (a_crd || a_cwr) a_col_cnt++;
        if (b_prea || b_ref) b_ref_cnt++;
        if (b_valid && b_ready) begin
            if (b_last != 0 && (cyc_b - b_last) != 18) b_gap_bad++;
            b_last = cyc_b;
            b_acc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_a(input int n);
        while (cyc_a < n) @(negedge clk);
    endtask

    task automatic wait_b(input int n);
        while (cyc_b < n) @(negedge clk);
    endtask

    typedef struct { int cyc; logic [12:0] strb; logic done; logic ready; } init_vec_t;
    typedef struct { int off; logic [12:0] strb; logic col; logic bb; logic ready; } req_vec_t;
    typedef struct { int cyc; logic [12:0] strb; logic ready; } ref_vec_t;

    init_vec_t iv[15];
    req_vec_t  rv[11];
    ref_vec_t  fv[19];

    task automatic run_init(input string tag);
        for (int i = 0; i < 15; i++) begin
            wait_a(iv[i].cyc);
            check($sformatf("%s_strb@%0d", tag, iv[i].cyc), 32'(a_strb), 32'(iv[i].strb));
            check($sformatf("%s_done@%0d", tag, iv[i].cyc), 32'(a_done), 32'(iv[i].done));
            check($sformatf("%s_ready@%0d", tag, iv[i].cyc), 32'(a_ready), 32'(iv[i].ready));
        end
    endtask

    task automatic run_req(input int t, input logic rd, input logic [2:0] ba,
                           input logic [13:0] ra, input logic [9:0] ca);
        logic [12:0] exp;
        wait_a(t + 1);
        a_valid = 1'b0;
        check($sformatf("addr_ba@%0d", t + 1), 32'(a_sba), 32'(ba));
        check($sformatf("addr_ra@%0d", t + 1), 32'(a_sra), 32'(ra));
        check($sformatf("addr_ca@%0d", t + 1), 32'(a_sca), 32'(ca));
        for (int i = 0; i < 11; i++) begin
            wait_a(t + rv[i].off);
            exp = rv[i].col ? (rd ? S_RD : S_WR) : rv[i].strb;
            check($sformatf("req_strb@t+%0d", rv[i].off), 32'(a_strb), 32'(exp));
            check($sformatf("req_bb@t+%0d", rv[i].off), 32'(a_bb), 32'(rv[i].bb));
            check($sformatf("req_ready@t+%0d", rv[i].off), 32'(a_ready), 32'(rv[i].ready));
        end
        check("addr_hold_ra", 32'(a_sra), 32'(ra));
    endtask

    task automatic do_req(input logic rd, input logic [2:0] ba, input logic [13:0] ra,
                          input logic [9:0] ca, output int t);
        a_valid = 1'b1; a_rd = rd; a_ba = ba; a_ra = ra; a_ca = ca;
        t = -1;
        for (int k = 0; k < 300; k++) begin
            if (a_ready) begin
                t = cyc_a;
                break;
            end
            @(negedge clk);
        end
        if (t < 0) begin
            check("accept_timeout", 32'(0), 32'(1));
            a_valid = 1'b0;
        end else begin
            run_req(t, rd, ba, ra, ca);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int snap;

        iv = '{'{1, S_RST, 0, 0}, '{8, S_RST, 0, 0}, '{9, S_CKE, 0, 0}, '{16, S_CKE, 0, 0},
               '{17, S_LMR0, 0, 0}, '{18, S_NONE, 0, 0}, '{21, S_LMR1, 0, 0}, '{25, S_LMR2, 0, 0},
               '{29, S_LMR3, 0, 0}, '{30, S_NONE, 0, 0}, '{40, S_NONE, 0, 0}, '{41, S_ZQ, 0, 0},
               '{42, S_NONE, 0, 0}, '{104, S_NONE, 0, 0}, '{105, S_NONE, 1, 1}};
        rv = '{'{1, S_NONE, 0, 1, 0}, '{2, S_ACT, 0, 0, 0}, '{3, S_NONE, 0, 0, 0},
               '{7, S_NONE, 0, 0, 0}, '{8, S_NONE, 1, 0, 0}, '{9, S_NONE, 0, 0, 0},
               '{11, S_NONE, 0, 0, 0}, '{12, S_PREC, 0, 0, 0}, '{13, S_NONE, 0, 0, 0},
               '{17, S_NONE, 0, 0, 0}, '{18, S_NONE, 0, 0, 1}};
        fv = '{'{105, S_NONE, 1}, '{106, S_NONE, 0}, '{113, S_RD, 0}, '{123, S_NONE, 1},
               '{141, S_NONE, 1}, '{153, S_PREC, 0}, '{158, S_NONE, 0}, '{159, S_NONE, 0},
               '{160, S_PREA, 0}, '{161, S_NONE, 0}, '{165, S_NONE, 0}, '{166, S_REF, 0},
               '{167, S_NONE, 0}, '{209, S_NONE, 0}, '{210, S_NONE, 0}, '{211, S_PREA, 0},
               '{217, S_REF, 0}, '{262, S_PREA, 0}, '{268, S_REF, 0}};

        rst_a = 1'b1; a_valid = 1'b0; a_rd = 1'b0; a_ba = '0; a_ra = '0; a_ca = '0;
        rst_b = 1'b1; b_valid = 1'b1; b_rd = 1'b1; b_ba = 3'd1; b_ra = 14'h0123; b_ca = 10'h055;
        repeat (3) @(negedge clk);

        check("rst_strb", 32'(a_strb), 32'(0));
        check("rst_bb", 32'(a_bb), 32'(0));
        check("rst_addr", 32'({a_sba, a_sra, a_sca}), 32'(0));
        check("rst_done", 32'(a_done), 32'(0));
        check("rst_ready", 32'(a_ready), 32'(0));
        rst_a = 1'b0;
        run_init("init");

        do_req(1'b1, 3'd3, 14'h01A5, 10'h040, t);
        check("rd_accept_cyc", 32'(t), 32'(105));
        do_req(1'b0, 3'd5, 14'h2C3A, 10'h3FF, t);
        check("wr_accept_cyc", 32'(t), 32'(123));

        // Reset while waiting between ACT and the column command.
        t = cyc_a;
        check("mid_ready", 32'(a_ready), 32'(1));
        a_valid = 1'b1; a_rd = 1'b0; a_ba = 3'd2; a_ra = 14'h0777; a_ca = 10'h123;
        wait_a(t + 1);
        a_valid = 1'b0;
        wait_a(t + 2);
        check("mid_act", 32'(a_strb), 32'(S_ACT));
        wait_a(t + 4);
        rst_a = 1'b1;
        snap = a_col_cnt;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("abort_strb%0d", k), 32'(a_strb), 32'(0));
            check($sformatf("abort_bb_addr%0d", k), 32'({a_bb, a_sba, a_sra, a_sca}), 32'(0));
            check($sformatf("abort_done_ready%0d", k), 32'({a_done, a_ready}), 32'(0));
        end
        // Request presented during the repeated init must wait for init_done.
        a_valid = 1'b1; a_rd = 1'b1; a_ba = 3'd7; a_ra = 14'h3FFF; a_ca = 10'h001;
        rst_a = 1'b0;
        run_init("reinit");
        check("no_col_after_abort", 32'(a_col_cnt), 32'(snap));
        run_req(105, 1'b1, 3'd7, 14'h3FFF, 10'h001);

        rst_b = 1'b0;
`ifdef DDR3_MCB_SEQ_REF_EN
        for (int i = 0; i < 19; i++) begin
            wait_b(fv[i].cyc);
            check($sformatf("ref_strb@%0d", fv[i].cyc), 32'(b_strb), 32'(fv[i].strb));
            check($sformatf("ref_ready@%0d", fv[i].cyc), 32'(b_ready), 32'(fv[i].ready));
        end
        check("ref_accept_cnt", 32'(b_acc), 32'(3));
`else
        wait_b(10000);
        check("noref_ref_prea_cnt", 32'(b_ref_cnt), 32'(0));
        check("noref_gap_bad", 32'(b_gap_bad), 32'(0));
        check("noref_accept_cnt", 32'(b_acc), 32'(550));
`endif
        check("no_strobe_overlap", 32'(overlap), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ddr3_mcb_seq.md
# ddr3_mcb_seq

Command sequencer for the DDR3 memory-controller back end. It runs the power-up and initialisation sequence, then serves single read/write requests with a closed-page policy and inserts periodic refresh. Every DRAM timing gap is enforced by cycle counting. It drives the one-hot command strobes and the bank/row/column address latch of the signal-register stage that follows it, and sits between the front-end request queue and that stage.

## Interface
Parameters:
- B_W, 3: bank address width
- R_W, 14: row address width
- C_W, 10: column address width
- T_RST, 8: reset-low hold, in cycles
- T_CKE, 8: CKE-low hold after reset release
- T_MRD, 4: mode-register-load to next command
- T_MOD, 12: last mode-register-load to ZQ
- T_ZQ, 64: ZQ calibration to init_done
- T_RCD, 6: activate to column command
- T_RTP, 4: column command to precharge
- T_RP, 6: precharge to next command
- T_RFC, 44: refresh to next command
- T_REFI, 3120: refresh interval

Ports:
- ddr3_mcb_clk  in  1  sole clock
- ddr3_mcb_rst  in  1  reset; synchronous, active-high
- req_valid  in  1  request present
- req_rd  in  1  1 = read, 0 = write
- req_ba / req_ra / req_ca  in  B_W / R_W / C_W  request address
- req_ready  out  1  request accepted on a cycle where valid and ready are both high
- seq_bb  out  1  address-latch strobe
- seq_ba / seq_ra / seq_ca  out  B_W / R_W / C_W  address driven alongside seq_bb
- i_rst, i_cke, i_lmr0, i_lmr1, i_lmr2, i_lmr3, i_zq  out  1 each  init command strobes
- c_prea, c_ref, c_prec, c_act, c_rd, c_wr  out  1 each  run-time command strobes
- init_done  out  1  initialisation complete (sticky)

## Operation
- All outputs are registered except req_ready, which is decoded from the state registers as (state == IDLE) && !ref_pend.
- At most one of the 13 command strobes is high in any cycle. Each command strobe is a single-cycle pulse, except i_rst and i_cke, which are level holds.
- A single 16-bit down-counter times every wait.
  - "X at cycle n, gap T" means the next command is issued at cycle n+T.
  - Every T_* parameter must satisfy 1 ≤ T < 65536.
- Init FSM:
  - RST: i_rst held high for T_RST cycles.
  - CKE: i_cke held high for T_CKE cycles.
  - LMR0, LMR1, LMR2, LMR3: one pulse each, spaced T_MRD.
  - Wait T_MOD, then ZQ: i_zq pulse.
  - Wait T_ZQ, then IDLE with init_done = 1.
- Run FSM:
  - IDLE → (request accepted) BB: seq_bb = 1 with the captured address.
  - BB → ACT: c_act.
  - ACT → (T_RCD) COL: c_rd if req_rd was 1, else c_wr.
  - COL → (T_RTP) PRE: c_prec.
  - PRE → (T_RP) IDLE.
- Refresh: the timer reloads T_REFI at init_done and on every expiry; expiry sets ref_pend.
  - In IDLE with ref_pend set: c_prea, then after T_RP c_ref (ref_pend clears in that cycle), then after T_RFC back to IDLE.
  - Refresh beats a pending request; req_ready stays 0 while ref_pend is set.
  - An expiry while ref_pend is already set is absorbed (ref_pend stays 1, no queueing).
- Address capture:
  - seq_ba, seq_ra and seq_ca are loaded on acceptance and hold until the next acceptance.
  - req_rd is latched on acceptance.

## Timing
- Reset values:
  - All strobes 0, seq_bb 0, seq_ba/seq_ra/seq_ca 0.
  - init_done 0, req_ready 0, ref_pend 0, FSM in RST.
  - i_rst goes high on the first cycle after reset is released.
- Asserting reset mid-operation, in any state, aborts the operation and repeats the full init sequence. No strobe fires in the reset cycle.
- Latency for a request accepted at cycle t:
  - seq_bb at t+1
  - c_act at t+2
  - column command at t+2+T_RCD
  - c_prec at t+2+T_RCD+T_RTP
  - req_ready high again at t+2+T_RCD+T_RTP+T_RP
- A request presented during init, during refresh, or while busy waits with req_valid held. It must keep its fields stable until accepted.
- If the refresh timer expires in the same cycle a request is accepted, the request completes first and the refresh is served in the following IDLE.

## Configuration
- DDR3_MCB_SEQ_REF_EN
  - Defined: the refresh timer and refresh path are built as described.
  - Undefined: no timer and ref_pend is tied to 0. c_prea and c_ref never assert, and req_ready = (state == IDLE).

## Structure
- Package ddr3_mcb_seq_pkg holds:
  - the init and run state enums
  - the 16-bit counter width constant
  - the default timing constants
- Sub-module ddr3_mcb_seq_timer: loadable 16-bit down-counter with load and value inputs and a done output. It is instantiated once for FSM gaps and once for T_REFI.

## Test plan
- Release reset with default parameters:
  - i_rst high for cycles 1–8, i_cke high for cycles 9–16
  - i_lmr0 at 17, i_lmr1 at 21, i_lmr2 at 25, i_lmr3 at 29
  - i_zq at 41, init_done at 105
- Read request ba=3, ra=0x1A5, ca=0x040, accepted at t: seq_bb with that address at t+1, c_act at t+2, c_rd at t+8, c_prec at t+12, req_ready high at t+18.
- Write request accepted at t: c_wr (not c_rd) at t+8; otherwise the same cycle pattern as the read.
- With T_REFI = 50 and req_valid held continuously:
  - after each expiry, c_prea in the next IDLE and c_ref T_RP later
  - req_ready low until T_RFC after c_ref
  - no strobe overlap anywhere
- Assert reset in the ACT→COL wait: no c_rd/c_wr issued, all outputs 0, init sequence restarts from i_rst.
- Build without DDR3_MCB_SEQ_REF_EN and run 10000 cycles of back-to-back requests: c_ref and c_prea never assert, and requests are accepted every 2+T_RCD+T_RTP+T_RP cycles.
